psram_burst_ctrl: RTL and testbench
===================================

# psram_burst_ctrl

Burst engine between the frame-buffer arbiter and the board's 16-bit asynchronous PSRAM. It accepts one Go/Wr/brst_Addr command at a time and moves BURST_LEN consecutive 16-bit words. Writes take data from the camera write FIFO; reads deliver data into the VGA read FIFO. Done tells the arbiter when the engine is ready for the next command.

## Interface
- BURST_LEN, 32: words per burst; brst_Addr is a word address.
- T_WR, 6: clk80 cycles with CE/WE low per write word; minimum 1.
- T_RD, 6: clk80 cycles with CE/OE low per read word; read data is sampled on the last of them; minimum 1.
- T_REC, 1: clk80 cycles with strobes high between words; minimum 1.
- clk80  in  1  system clock, 80 MHz.
- rst  in  1  reset, asynchronous, active-high.
- Go  in  1  command request from the arbiter (level).
- Wr  in  1  1 = write burst, 0 = read burst.
- brst_Addr  in  23  burst base word address.
- Done  out  1  high = idle and ready; low = busy.
- cam_data  in  16  camera FIFO head word (first-word-fall-through).
- cam_empty  in  1  camera FIFO empty.
- cam_rd_en  out  1  one-cycle pop of the camera FIFO.
- vga_data  out  16  read word to the VGA FIFO.
- vga_full  in  1  VGA FIFO full.
- vga_wr_en  out  1  one-cycle push to the VGA FIFO.
- mem_addr  out  23  PSRAM address.
- mem_dq_o  out  16  PSRAM write data.
- mem_dq_i  in  16  PSRAM read data.
- mem_dq_oe  out  1  data bus drive enable.
- mem_ce_n, mem_we_n, mem_oe_n, mem_ub_n, mem_lb_n  out  1 each  PSRAM strobes, active-low.
- mem_adv_n, mem_clk, mem_cre  out  1 each  tied to 0 (asynchronous mode).

## Operation
State machine states: IDLE, ARM, SETUP, STROBE, REC, FIN.
- **IDLE:** Done=1, all strobes high. If Go=1 at a clock edge, go to ARM and drive Done=0.
- **ARM:** latch base=brst_Addr, wr=Wr; clear beat to 0; go to SETUP.
  - Latching one cycle after Go is seen is intentional: the arbiter updates brst_Addr one cycle after it raises Go.
- **SETUP (per word):**
  - mem_addr = (base + beat) mod 2^23; on a full-scale carry, wrap to 0.
  - Write: if cam_empty=1, stay in SETUP with strobes high. Otherwise load mem_dq_o=cam_data, set mem_dq_oe=1, pulse cam_rd_en for 1 cycle, go to STROBE.
  - Read: if vga_full=1, stay in SETUP. Otherwise go to STROBE.
- **STROBE:** runs T_WR cycles (write) or T_RD cycles (read).
  - mem_ce_n=0, mem_ub_n=0, mem_lb_n=0 throughout.
  - Write: mem_we_n=0.
  - Read: mem_oe_n=0. On the last cycle, capture vga_data=mem_dq_i.
  - Then go to REC.
- **REC:** runs T_REC cycles, all strobes high.
  - Write: mem_dq_oe stays 1 through REC for data hold, then drops to 0.
  - Read: vga_wr_en pulses in the first REC cycle.
  - After REC: if beat==BURST_LEN-1, go to FIN; otherwise beat+1 and go to SETUP.
- **FIN:** if Go=0, go to IDLE (Done=1 from the next cycle). If Go=1, stay with Done=0. A burst is never restarted by the same Go level.
- Go, Wr and brst_Addr are ignored outside IDLE and ARM.
- mem_addr holds its last value between bursts.

## Timing
- Reset values:
  - Done=1; mem_ce_n, mem_we_n, mem_oe_n, mem_ub_n, mem_lb_n = 1.
  - mem_dq_oe=0, mem_dq_o=0, mem_addr=0, vga_data=0.
  - cam_rd_en=0, vga_wr_en=0; mem_adv_n, mem_clk, mem_cre = 0.
  - State = IDLE.
- Reset asserted mid-burst: outputs return to reset values immediately (asynchronously). No partial word is completed. The FIFOs are not popped or pushed again.
- Go sampled high at edge k: Done=0 after edge k; base is latched at edge k+1.
- Cycles per word without stalls: 1+T_WR+T_REC (write) or 1+T_RD+T_REC (read). At defaults this is 8 cycles.
- With Go already low, Done returns high after edge k+2+BURST_LEN*8 at defaults (k+258).
- Each FIFO stall adds exactly one SETUP cycle per stalled cycle. While stalled, mem_ce_n stays 1.
- cam_rd_en: at most one pulse per write word. vga_wr_en: exactly one pulse per read word, 1 cycle after the data capture.

## Test plan
- **Write burst:** Go=1 for 3 cycles, Wr=1, brst_Addr=0x000040 valid from the 2nd Go cycle, FIFO holding 0x1000..0x101F.
  - Expect 32 WE pulses, each 6 cycles wide, at addresses 0x40..0x5F with data 0x1000..0x101F.
  - Expect 32 cam_rd_en pulses; Done high again at k+258.
- **Read burst:** Wr=0, brst_Addr=0x000100, PSRAM model returns addr^0xA5A5.
  - Expect 32 vga_wr_en pulses with matching vga_data.
  - mem_we_n and mem_dq_oe stay 0 throughout.
- **Stalls:**
  - cam_empty=1 for 10 cycles before word 5: Done delayed by exactly 10 cycles; no strobe during the stall.
  - vga_full=1 for 4 cycles on a read: Done delayed by exactly 4 cycles.
- **Go held high past the burst:** Done stays 0 in FIN until Go falls. Done=1 the cycle after; no second burst starts.
- **Wrap:** brst_Addr=0x7FFFF0 with BURST_LEN=32: addresses 0x7FFFF0..0x7FFFFF, then 0x000000..0x00000F.
- **Reset mid-burst:** rst pulses during STROBE of word 7. All outputs are at reset values while rst is high. The next Go starts a fresh burst at beat 0.

Source files
------------

// File: rtl/psram_burst_ctrl_if.sv
// Signal bundle between the PSRAM burst engine, the frame-buffer arbiter,
// the camera/VGA FIFOs and the PSRAM pins. The engine takes the slave view.
interface psram_burst_ctrl_if;
  // Arbiter command channel
  logic        Go;
  logic        Wr;
  logic [22:0] brst_Addr;
  logic        Done;
  // Camera write FIFO (first-word-fall-through)
  logic [15:0] cam_data;
  logic        cam_empty;
  logic        cam_rd_en;
  // VGA read FIFO
  logic [15:0] vga_data;
  logic        vga_full;
  logic        vga_wr_en;
  // PSRAM pins
  logic [22:0] mem_addr;
  logic [15:0] mem_dq_o;
  logic [15:0] mem_dq_i;
  logic        mem_dq_oe;
  logic        mem_ce_n;
  logic        mem_we_n;
  logic        mem_oe_n;
  logic        mem_ub_n;
  logic        mem_lb_n;
  logic        mem_adv_n;
  logic        mem_clk;
  logic        mem_cre;

  modport slave (
    input  Go, Wr, brst_Addr, cam_data, cam_empty, vga_full, mem_dq_i,
    output Done, cam_rd_en, vga_data, vga_wr_en, mem_addr, mem_dq_o, mem_dq_oe,
           mem_ce_n, mem_we_n, mem_oe_n, mem_ub_n, mem_lb_n,
           mem_adv_n, mem_clk, mem_cre
  );

  modport master (
    output Go, Wr, brst_Addr, cam_data, cam_empty, vga_full, mem_dq_i,
    input  Done, cam_rd_en, vga_data, vga_wr_en, mem_addr, mem_dq_o, mem_dq_oe,
           mem_ce_n, mem_we_n, mem_oe_n, mem_ub_n, mem_lb_n,
           mem_adv_n, mem_clk, mem_cre
  );
endinterface

// File: rtl/psram_burst_ctrl.sv
// Burst engine: moves BURST_LEN consecutive 16-bit words between the camera /
// VGA FIFOs and an asynchronous PSRAM, one Go/Wr/brst_Addr command at a time.
module psram_burst_ctrl #(
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned T_WR      = 6,
  parameter int unsigned T_RD      = 6,
  parameter int unsigned T_REC     = 1
) (
  input  logic              clk80,
  input  logic              rst,
  psram_burst_ctrl_if.slave bus
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  // Phase timer width; covers strobe/recovery lengths up to 256 cycles.
  localparam int unsigned TW = 8;

  localparam logic [TW-1:0] WR_LAST   = TW'(T_WR - 1);
  localparam logic [TW-1:0] RD_LAST   = TW'(T_RD - 1);
  localparam logic [TW-1:0] REC_LAST  = TW'(T_REC - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, ARM, SETUP, STROBE, REC, FIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          wr_q;
  logic [BW-1:0] beat;
  logic [TW-1:0] tcnt;

  logic strobe_last;
  logic rec_last;
  logic setup_go;
  logic last_beat;

  assign strobe_last = (tcnt == (wr_q ? WR_LAST : RD_LAST));
  assign rec_last    = (tcnt == REC_LAST);
  // A word may start only when its FIFO can source/sink it this cycle.
  assign setup_go    = wr_q ? !bus.cam_empty : !bus.vga_full;
  assign last_beat   = (beat == BEAT_LAST);

  // Asynchronous mode: no burst clock, no address-valid, no config access.
  assign bus.mem_adv_n = 1'b0;
  assign bus.mem_clk   = 1'b0;
  assign bus.mem_cre   = 1'b0;

  // State register; reset drops every strobe immediately through IDLE decoding.
  always_ff @(posedge clk80 or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe/handshake decoding from the current state.
  always_comb begin
    // NOTE: every output is defaulted before the case, so no path can infer a latch.
    state_nxt     = state;
    bus.Done      = 1'b0;
    bus.mem_ce_n  = 1'b1;
    bus.mem_we_n  = 1'b1;
    bus.mem_oe_n  = 1'b1;
    bus.mem_ub_n  = 1'b1;
    bus.mem_lb_n  = 1'b1;
    bus.mem_dq_oe = 1'b0;
    bus.cam_rd_en = 1'b0;
    bus.vga_wr_en = 1'b0;
    case (state)
      IDLE: begin
        bus.Done = 1'b1;
        if (bus.Go) state_nxt = ARM;
      end
      ARM: state_nxt = SETUP;
      SETUP: begin
        if (setup_go) begin
          bus.cam_rd_en = wr_q;
          state_nxt     = STROBE;
        end
      end
      STROBE: begin
        bus.mem_ce_n  = 1'b0;
        bus.mem_ub_n  = 1'b0;
        bus.mem_lb_n  = 1'b0;
        bus.mem_we_n  = !wr_q;
        bus.mem_oe_n  = wr_q;
        bus.mem_dq_oe = wr_q;
        if (strobe_last) state_nxt = REC;
      end
      REC: begin
        // Write data is held on the bus through recovery.
        bus.mem_dq_oe = wr_q;
        bus.vga_wr_en = !wr_q && (tcnt == '0);
        if (rec_last) state_nxt = last_beat ? FIN : SETUP;
      end
      FIN: begin
        // Wait for Go to drop so one Go level never launches a second burst.
        if (!bus.Go) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst datapath: command latch, beat/phase counters, address and data registers.
  always_ff @(posedge clk80 or posedge rst) begin
    if (rst) begin
      wr_q         <= 1'b0;
      beat         <= '0;
      tcnt         <= '0;
      bus.mem_addr <= '0;
      bus.mem_dq_o <= '0;
      bus.vga_data <= '0;
    end else begin
      case (state)
        ARM: begin
          // The arbiter presents brst_Addr one cycle after raising Go.
          wr_q         <= bus.Wr;
          beat         <= '0;
          bus.mem_addr <= bus.brst_Addr;
        end
        SETUP: begin
          tcnt <= '0;
          if (setup_go && wr_q) bus.mem_dq_o <= bus.cam_data;
        end
        STROBE: begin
          tcnt <= strobe_last ? '0 : tcnt + TW'(1);
          if (strobe_last && !wr_q) bus.vga_data <= bus.mem_dq_i;
        end
        REC: begin
          tcnt <= tcnt + TW'(1);
          if (rec_last && !last_beat) begin
            beat         <= beat + BW'(1);
            // 23-bit increment wraps 0x7FFFFF to 0x000000.
            bus.mem_addr <= bus.mem_addr + 23'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_burst_ctrl.sv
// Self-checking bench for psram_burst_ctrl: FIFO and PSRAM models, a strobe
// scoreboard and per-scenario tasks for bursts, stalls, wrap, Go hold and reset.
module tb_psram_burst_ctrl;

  localparam int BL      = 32;
  localparam int TWR     = 6;
  localparam int TRD     = 6;
  localparam int TREC    = 1;
  localparam int CYC_W   = 1 + TWR + TREC;
  localparam int CYC_R   = 1 + TRD + TREC;
  localparam int TIMEOUT = 2000;

  localparam logic [66:0] RESET_OUTS = {1'b1, 5'b11111, 1'b0, 16'h0000, 23'h000000,
                                        16'h0000, 1'b0, 1'b0, 3'b000};

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] data;
    logic        we;
    logic [7:0]  width;
  } beat_t;

  logic clk80 = 1'b0;
  logic rst   = 1'b1;

  psram_burst_ctrl_if bus ();

  psram_burst_ctrl #(
    .BURST_LEN(BL),
    .T_WR     (TWR),
    .T_RD     (TRD),
    .T_REC    (TREC)
  ) dut (
    .clk80(clk80),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk80 = ~clk80;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  string       cur_test = "none";
  logic [15:0] cam_q[$];
  beat_t       exp_q[$];
  logic [15:0] exp_vga[$];
  int          cam_pops, vga_pushes, rd_bad, win_strobes;
  int          cam_blk_lo, cam_blk_hi, vga_blk_lo, vga_blk_hi, win_lo, win_hi;
  logic        pop_pending, in_run, sb_on;
  beat_t       run;

  function automatic logic [66:0] outs();
    return {bus.Done, bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n, bus.mem_ub_n, bus.mem_lb_n,
            bus.mem_dq_oe, bus.mem_dq_o, bus.mem_addr, bus.vga_data, bus.cam_rd_en,
            bus.vga_wr_en, bus.mem_adv_n, bus.mem_clk, bus.mem_cre};
  endfunction

  task automatic clear_obs();
    exp_q.delete();
    exp_vga.delete();
    cam_q.delete();
    cam_pops    = 0;
    vga_pushes  = 0;
    rd_bad      = 0;
    win_strobes = 0;
    pop_pending = 1'b0;
    in_run      = 1'b0;
    cam_blk_lo  = -1; cam_blk_hi = -2;
    vga_blk_lo  = -1; vga_blk_hi = -2;
    win_lo      = -1; win_hi     = -2;
  endtask

  // Load the FIFO/PSRAM model and push the expected strobes and VGA words.
  task automatic load_burst(input logic wr, input logic [22:0] base, input logic [15:0] first);
    logic [22:0] a;
    for (int i = 0; i < BL; i++) begin
      a = base + 23'(i);
      if (wr) begin
        cam_q.push_back(first + 16'(i));
        exp_q.push_back(beat_t'{addr: a, data: first + 16'(i), we: 1'b1, width: 8'(TWR)});
      end else begin
        exp_q.push_back(beat_t'{addr: a, data: 16'h0000, we: 1'b0, width: 8'(TRD)});
        exp_vga.push_back(a[15:0] ^ 16'hA5A5);
      end
    end
  endtask

  // Scoreboard side: observe outputs, compare completed strobes and VGA pushes.
  task automatic monitor();
    beat_t       e;
    logic [15:0] ev;
    if (bus.cam_rd_en) begin
      cam_pops++;
      pop_pending = 1'b1;
    end
    if (!bus.mem_we_n || bus.mem_dq_oe) rd_bad++;
    if (!bus.mem_ce_n && cyc >= win_lo && cyc <= win_hi) win_strobes++;
    if (!bus.mem_ce_n) begin
      if (!in_run) begin
        in_run = 1'b1;
        run = beat_t'{addr: bus.mem_addr, data: bus.mem_we_n ? 16'h0000 : bus.mem_dq_o,
                      we: !bus.mem_we_n, width: 8'd0};
      end
      run.width = run.width + 8'd1;
    end else if (in_run) begin
      in_run = 1'b0;
      if (sb_on) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s strobe_extra: got strobe at addr=%h, required no further strobe",
                   cur_test, run.addr);
        end else begin
          e = exp_q.pop_front();
          if (run !== e) begin
            fails++;
            $display("FAIL %s strobe: got addr=%h data=%h we=%b width=%0d, required addr=%h data=%h we=%b width=%0d",
                     cur_test, run.addr, run.data, run.we, run.width, e.addr, e.data, e.we, e.width);
          end
        end
      end
    end
    if (bus.vga_wr_en) begin
      vga_pushes++;
      if (sb_on) begin
        tests++;
        if (exp_vga.size() == 0) begin
          fails++;
          $display("FAIL %s vga_extra: got push %h, required no further push", cur_test, bus.vga_data);
        end else begin
          ev = exp_vga.pop_front();
          if (bus.vga_data !== ev) begin
            fails++;
            $display("FAIL %s vga_data: got %h, required %h", cur_test, bus.vga_data, ev);
          end
        end
      end
    end
  endtask

  // One clock: retire the FIFO pop of the previous edge, drive models, then sample.
  task automatic step();
    @(posedge clk80);
    #1;
    cyc++;
    if (pop_pending) begin
      if (cam_q.size() > 0) void'(cam_q.pop_front());
      pop_pending = 1'b0;
    end
    bus.cam_empty = (cam_q.size() == 0) || (cyc >= cam_blk_lo && cyc <= cam_blk_hi);
    bus.cam_data  = (cam_q.size() > 0) ? cam_q[0] : 16'h0000;
    bus.vga_full  = (cyc >= vga_blk_lo && cyc <= vga_blk_hi);
    bus.mem_dq_i  = bus.mem_addr[15:0] ^ 16'hA5A5;
    #1;
    monitor();
  endtask

  // Raise Go for go_len cycles (0 = leave high); brst_Addr is valid from the 2nd Go cycle.
  task automatic run_burst(input logic wr, input logic [22:0] base, input int go_len, output int k);
    bus.Wr        = wr;
    bus.brst_Addr = ~base;
    bus.Go        = 1'b1;
    k             = cyc + 1;
    for (int i = 0; i < ((go_len > 0) ? go_len : 1); i++) begin
      step();
      if (i == 0) bus.brst_Addr = base;
    end
    if (go_len > 0) bus.Go = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = -1;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (bus.Done === 1'b1) begin
        lat = cyc - k;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst = 1'b1;
    step();
    step();
    tests++;
    if (outs() !== RESET_OUTS) begin
      fails++;
      $display("FAIL reset outputs: got %h, required %h", outs(), RESET_OUTS);
    end
    rst = 1'b0;
    step();
    tests++;
    if (bus.Done !== 1'b1 || bus.mem_ce_n !== 1'b1) begin
      fails++;
      $display("FAIL reset idle: got Done=%b ce_n=%b, required Done=1 ce_n=1", bus.Done, bus.mem_ce_n);
    end
  endtask

  task automatic test_write_burst();
    int k, lat;
    cur_test = "write_burst";
    clear_obs();
    load_burst(1'b1, 23'h000040, 16'h1000);
    sb_on = 1'b1;
    run_burst(1'b1, 23'h000040, 3, k);
    wait_done(k, lat);
    tests++;
    if (lat !== 2 + BL * CYC_W) begin
      fails++;
      $display("FAIL write_burst done_latency: got %0d, required %0d", lat, 2 + BL * CYC_W);
    end
    tests++;
    if (cam_pops !== BL || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL write_burst counts: got pops=%0d missing=%0d, required pops=%0d missing=0",
               cam_pops, exp_q.size(), BL);
    end
  endtask

  task automatic test_read_burst();
    int k, lat;
    cur_test = "read_burst";
    clear_obs();
    load_burst(1'b0, 23'h000100, 16'h0000);
    run_burst(1'b0, 23'h000100, 3, k);
    wait_done(k, lat);
    tests++;
    if (lat !== 2 + BL * CYC_R) begin
      fails++;
      $display("FAIL read_burst done_latency: got %0d, required %0d", lat, 2 + BL * CYC_R);
    end
    tests++;
    if (vga_pushes !== BL || exp_q.size() !== 0 || exp_vga.size() !== 0 || rd_bad !== 0) begin
      fails++;
      $display("FAIL read_burst counts: got pushes=%0d missing=%0d/%0d we_or_oe=%0d, required pushes=%0d missing=0/0 we_or_oe=0",
               vga_pushes, exp_q.size(), exp_vga.size(), rd_bad, BL);
    end
  endtask

  task automatic test_write_stall();
    int k, lat;
    cur_test = "write_stall";
    clear_obs();
    load_burst(1'b1, 23'h000500, 16'h2000);
    run_burst(1'b1, 23'h000500, 1, k);
    // Word 5 enters SETUP after edge k+1+5*CYC_W; hold the FIFO empty 10 cycles there.
    cam_blk_lo = k + 1 + 5 * CYC_W;
    cam_blk_hi = cam_blk_lo + 9;
    win_lo     = cam_blk_lo;
    win_hi     = cam_blk_hi + 1;
    wait_done(k, lat);
    tests++;
    if (lat !== 2 + BL * CYC_W + 10) begin
      fails++;
      $display("FAIL write_stall done_latency: got %0d, required %0d", lat, 2 + BL * CYC_W + 10);
    end
    tests++;
    if (win_strobes !== 0 || cam_pops !== BL || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL write_stall counts: got stall_strobes=%0d pops=%0d missing=%0d, required 0/%0d/0",
               win_strobes, cam_pops, exp_q.size(), BL);
    end
  endtask

  task automatic test_read_stall_wrap();
    int k, lat;
    cur_test = "read_stall_wrap";
    clear_obs();
    load_burst(1'b0, 23'h7FFFF0, 16'h0000);
    run_burst(1'b0, 23'h7FFFF0, 1, k);
    vga_blk_lo = k + 1 + 3 * CYC_R;
    vga_blk_hi = vga_blk_lo + 3;
    wait_done(k, lat);
    tests++;
    if (lat !== 2 + BL * CYC_R + 4) begin
      fails++;
      $display("FAIL read_stall_wrap done_latency: got %0d, required %0d", lat, 2 + BL * CYC_R + 4);
    end
    tests++;
    if (bus.mem_addr !== 23'h00000F) begin
      fails++;
      $display("FAIL read_stall_wrap last_addr: got %h, required 00000f", bus.mem_addr);
    end
    tests++;
    if (vga_pushes !== BL || exp_q.size() !== 0 || rd_bad !== 0) begin
      fails++;
      $display("FAIL read_stall_wrap counts: got pushes=%0d missing=%0d we_or_oe=%0d, required %0d/0/0",
               vga_pushes, exp_q.size(), rd_bad, BL);
    end
  endtask

  task automatic test_go_hold();
    int k;
    int done_hi = 0;
    int strobes = 0;
    cur_test = "go_hold";
    clear_obs();
    load_burst(1'b0, 23'h001234, 16'h0000);
    run_burst(1'b0, 23'h001234, 0, k);
    while (cyc < k + 300) begin
      if (bus.Done !== 1'b0) done_hi++;
      step();
    end
    tests++;
    if (done_hi !== 0 || vga_pushes !== BL) begin
      fails++;
      $display("FAIL go_hold fin: got done_high=%0d pushes=%0d, required 0/%0d", done_hi, vga_pushes, BL);
    end
    bus.Go = 1'b0;
    step();
    tests++;
    if (bus.Done !== 1'b1) begin
      fails++;
      $display("FAIL go_hold release: got Done=%b, required 1", bus.Done);
    end
    repeat (20) begin
      step();
      if (!bus.mem_ce_n || !bus.Done) strobes++;
    end
    tests++;
    if (strobes !== 0 || vga_pushes !== BL) begin
      fails++;
      $display("FAIL go_hold restart: got busy_cycles=%0d pushes=%0d, required 0/%0d", strobes, vga_pushes, BL);
    end
  endtask

  task automatic test_reset_mid_burst();
    int k, lat;
    int busy = 0;
    cur_test = "reset_mid_burst";
    clear_obs();
    sb_on = 1'b0;
    load_burst(1'b1, 23'h000200, 16'h3000);
    run_burst(1'b1, 23'h000200, 1, k);
    while (cyc < k + 3 + 7 * CYC_W) step();
    tests++;
    if (bus.mem_we_n !== 1'b0 || bus.mem_addr !== 23'h000207) begin
      fails++;
      $display("FAIL reset_mid_burst pre: got we_n=%b addr=%h, required we_n=0 addr=000207",
               bus.mem_we_n, bus.mem_addr);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (outs() !== RESET_OUTS) begin
      fails++;
      $display("FAIL reset_mid_burst async: got %h, required %h", outs(), RESET_OUTS);
    end
    step();
    step();
    tests++;
    if (outs() !== RESET_OUTS) begin
      fails++;
      $display("FAIL reset_mid_burst held: got %h, required %h", outs(), RESET_OUTS);
    end
    rst = 1'b0;
    repeat (10) begin
      step();
      if (!bus.mem_ce_n || !bus.Done) busy++;
    end
    tests++;
    if (cam_pops !== 8 || busy !== 0) begin
      fails++;
      $display("FAIL reset_mid_burst after: got pops=%0d busy_cycles=%0d, required 8/0", cam_pops, busy);
    end
    clear_obs();
    load_burst(1'b1, 23'h000300, 16'h4000);
    sb_on = 1'b1;
    run_burst(1'b1, 23'h000300, 1, k);
    wait_done(k, lat);
    tests++;
    if (lat !== 2 + BL * CYC_W || cam_pops !== BL || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL reset_mid_burst fresh: got latency=%0d pops=%0d missing=%0d, required %0d/%0d/0",
               lat, cam_pops, exp_q.size(), 2 + BL * CYC_W, BL);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Go        = 1'b0;
    bus.Wr        = 1'b0;
    bus.brst_Addr = 23'h000000;
    bus.cam_data  = 16'h0000;
    bus.cam_empty = 1'b1;
    bus.vga_full  = 1'b0;
    bus.mem_dq_i  = 16'h0000;
    sb_on         = 1'b1;
    run           = '0;
    clear_obs();
    test_reset();
    test_write_burst();
    test_read_burst();
    test_write_stall();
    test_read_stall_wrap();
    test_go_hold();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
